multicycle_ctrl: RTL and testbench

- Moore-style sequencing FSM that replaces the single-cycle control decoder when the CPU moves to a multicycle datapath.
- The datapath has one shared instruction/data memory, IR/MDR/A/B/ALUOut registers and one ALU.
- The controller issues per-cycle datapath enables and mux selects and stalls on a memory ready handshake.
- It flags illegal instructions and memory timeouts.

---
 rtl/multicycle_ctrl_pkg.sv | 66 ++++++
 rtl/multicycle_ctrl_if.sv | 42 ++++
 rtl/multicycle_ctrl_alu_op_decode.sv | 38 +++
 rtl/multicycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, functs, ALU ops, states, mux selects.
// Pure declarations; no latency or flow control of its own.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ASRC_PC    = 2'b00;
    localparam logic [1:0] ASRC_REGA  = 2'b01;
    localparam logic [1:0] ASRC_SHAMT = 2'b10;

    localparam logic [1:0] BSRC_REGB  = 2'b00;
    localparam logic [1:0] BSRC_FOUR  = 2'b01;
    localparam logic [1:0] BSRC_EXT   = 2'b10;
    localparam logic [1:0] BSRC_EXTSH = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTYPE  = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_HALT   = 4'd13
    } state_e;

    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and memory handshake in, enables and mux selects out.
// Wiring only; master is the controller, slave is the datapath/memory side.
interface multicycle_ctrl_if #(
    parameter int ALUOP_W = 4
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               alu_zero;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_write;
    logic               iord;
    logic               ir_write;
    logic               pc_write;
    logic               pc_write_cond;
    logic               branch_ne;
    logic [1:0]         pc_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic               sign_ext;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               illegal;
    logic               bus_err;
    logic [3:0]         state_o;

    modport master (
        input  op, funct, alu_zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne,
               pc_src, alu_src_a, alu_src_b, sign_ext, alu_op, reg_dst, mem_to_reg,
               reg_write, illegal, bus_err, state_o
    );

    modport slave (
        output op, funct, alu_zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne,
               pc_src, alu_src_a, alu_src_b, sign_ext, alu_op, reg_dst, mem_to_reg,
               reg_write, illegal, bus_err, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational op/funct -> ALU operation for R-type and immediate-ALU instructions.
// Zero latency, no flow control; o_illegal flags anything that is not an ALU instruction.
module alu_op_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic [5:0]         i_op,
    input  logic [5:0]         i_funct,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_illegal
);

    always_comb begin
        o_alu_op  = ALUOP_W'(ALU_ADD);
        o_illegal = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  o_alu_op = ALUOP_W'(ALU_ADD);
                    FN_SUB:  o_alu_op = ALUOP_W'(ALU_SUB);
                    FN_AND:  o_alu_op = ALUOP_W'(ALU_AND);
                    FN_OR:   o_alu_op = ALUOP_W'(ALU_OR);
                    FN_SLT:  o_alu_op = ALUOP_W'(ALU_SLT);
                    FN_SLL:  o_alu_op = ALUOP_W'(ALU_SLL);
                    FN_SRL:  o_alu_op = ALUOP_W'(ALU_SRL);
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_ADDI: o_alu_op = ALUOP_W'(ALU_ADD);
            OP_ANDI: o_alu_op = ALUOP_W'(ALU_AND);
            OP_ORI:  o_alu_op = ALUOP_W'(ALU_OR);
            OP_SLTI: o_alu_op = ALUOP_W'(ALU_SLT);
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU sequencer: Moore FSM issuing datapath enables/selects; lw 5, sw/R/imm 4, branch/j 3 cycles.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; MEM_TIMEOUT wait cycles set sticky bus_err and HALT.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALUOP_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_e              r_state;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_bus_err;
    logic [ALUOP_W-1:0]  w_dec_alu_op;
    logic                w_dec_illegal;
    logic                w_mem_state;
    logic                w_timeout;
    logic                w_op_known;

    alu_op_decode #(.ALUOP_W(ALUOP_W)) u_alu_op_decode (
        .i_op      (bus.op),
        .i_funct   (bus.funct),
        .o_alu_op  (w_dec_alu_op),
        .o_illegal (w_dec_illegal)
    );

    assign w_mem_state = is_mem_state(r_state);
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && !bus.mem_ready &&
                         (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
    assign w_op_known  = bus.op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_J,
                                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            // Counter clears whenever a wait ends or a non-memory state is active,
            // so every entry into a memory state starts from zero.
            if (w_mem_state && !bus.mem_ready && !w_timeout)
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;

            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW:                      r_state <= S_MEMADR;
                        OP_RTYPE:                          r_state <= S_RTYPE;
                        OP_BEQ, OP_BNE:                    r_state <= S_BRANCH;
                        OP_J:                              r_state <= S_JUMP;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: r_state <= S_IEXEC;
                        default:                           r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (bus.mem_ready) r_state <= S_MEMWB;
                S_MEMWR:  if (bus.mem_ready) r_state <= S_FETCH;
                S_RTYPE:  r_state <= w_dec_illegal ? S_FETCH : S_RWB;
                S_IEXEC:  r_state <= S_IWB;
                S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: r_state <= S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_IDLE;
            endcase

            if (w_timeout) begin
                r_state   <= S_HALT;
                r_bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pc_src        = PCSRC_ALU;
        bus.alu_src_a     = ASRC_PC;
        bus.alu_src_b     = BSRC_REGB;
        bus.sign_ext      = 1'b0;
        bus.alu_op        = '0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.illegal       = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = BSRC_FOUR;
                bus.alu_op    = ALUOP_W'(ALU_ADD);
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = BSRC_EXTSH;
                bus.sign_ext  = 1'b1;
                bus.alu_op    = ALUOP_W'(ALU_ADD);
                bus.illegal   = !w_op_known;
            end
            S_MEMADR: begin
                bus.alu_src_a = ASRC_REGA;
                bus.alu_src_b = BSRC_EXT;
                bus.sign_ext  = 1'b1;
                bus.alu_op    = ALUOP_W'(ALU_ADD);
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_RTYPE: begin
                bus.alu_src_a = (bus.funct == FN_SLL || bus.funct == FN_SRL) ? ASRC_SHAMT : ASRC_REGA;
                bus.alu_op    = w_dec_alu_op;
                bus.illegal   = w_dec_illegal;
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = ASRC_REGA;
                bus.alu_op        = ALUOP_W'(ALU_SUB);
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = PCSRC_ALUOUT;
                bus.branch_ne     = (bus.op == OP_BNE);
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PCSRC_JUMP;
            end
            S_IEXEC: begin
                bus.alu_src_a = ASRC_REGA;
                bus.alu_src_b = BSRC_EXT;
                bus.sign_ext  = !(bus.op == OP_ANDI || bus.op == OP_ORI);
                bus.alu_op    = w_dec_alu_op;
            end
            S_IWB: begin
                bus.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.bus_err = r_bus_err;
    assign bus.state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: reset, per-instruction sequencing, illegal decode, memory timeout.
// Inputs change 2ns after the rising edge; outputs are sampled 1ns later.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.ALUOP_W(4)) bus();

    multicycle_ctrl #(.MEM_TIMEOUT(16), .ALUOP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [21:0] w_ctl;
    assign w_ctl = {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
                    bus.pc_write_cond, bus.branch_ne, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
                    bus.sign_ext, bus.alu_op, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.illegal};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0] st;
        logic       ill, rw, mreq, bne, pwc, rdst, sext;
        logic [1:0] asrc, psrc;
        logic [3:0] aop;
    } snap_t;

    snap_t snaps[32];
    int    ncyc;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction from FETCH with zero-wait memory, recording every cycle.
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z);
        bus.op = o; bus.funct = f; bus.alu_zero = z; bus.mem_ready = 1'b1;
        ncyc = 0;
        do begin
            #1;
            snaps[ncyc] = {bus.state_o, bus.illegal, bus.reg_write, bus.mem_req, bus.branch_ne,
                           bus.pc_write_cond, bus.reg_dst, bus.sign_ext, bus.alu_src_a,
                           bus.pc_src, bus.alu_op};
            ncyc++;
            tick();
        end while (bus.state_o != S_FETCH && ncyc < 30);
    endtask

    function automatic int cnt(input int which);
        int c = 0;
        for (int i = 0; i < ncyc; i++) begin
            case (which)
                0:       c += int'(snaps[i].ill);
                1:       c += int'(snaps[i].rw);
                default: c += int'(snaps[i].mreq);
            endcase
        end
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b0;
        bus.op = '0; bus.funct = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
        #1;
        chk("rst_state0", bus.state_o, S_IDLE);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ctl", w_ctl, 0);
            chk("rst_buserr", bus.bus_err, 0);
            chk("rst_state", bus.state_o, S_IDLE);
        end
        rst = 1'b1;
        #1 chk("idle_after_rel", bus.state_o, S_IDLE);
        tick();
        chk("fetch_after_idle", bus.state_o, S_FETCH);

        // lw with two wait cycles in FETCH and MEMRD
        bus.op = OP_LW; bus.mem_ready = 1'b0;
        #1;
        chk("f1_memreq", bus.mem_req, 1);
        chk("f1_iord", bus.iord, 0);
        chk("f1_irw", bus.ir_write, 0);
        chk("f1_srcb", bus.alu_src_b, 2'b01);
        chk("f1_aluop", bus.alu_op, 4'b0010);
        tick(); #1;
        chk("f2_state", bus.state_o, S_FETCH);
        chk("f2_pcw", bus.pc_write, 0);
        tick(); bus.mem_ready = 1'b1; #1;
        chk("f3_state", bus.state_o, S_FETCH);
        chk("f3_irw", bus.ir_write, 1);
        chk("f3_pcw", bus.pc_write, 1);
        tick(); bus.mem_ready = 1'b0; #1;
        chk("dec_state", bus.state_o, S_DECODE);
        chk("dec_srcb", bus.alu_src_b, 2'b11);
        chk("dec_sext", bus.sign_ext, 1);
        tick(); #1;
        chk("madr_state", bus.state_o, S_MEMADR);
        chk("madr_srca", bus.alu_src_a, 2'b01);
        chk("madr_srcb", bus.alu_src_b, 2'b10);
        tick(); #1;
        chk("mrd1_state", bus.state_o, S_MEMRD);
        chk("mrd1_iord", bus.iord, 1);
        chk("mrd1_rw", bus.reg_write, 0);
        tick(); #1;
        chk("mrd2_state", bus.state_o, S_MEMRD);
        tick(); bus.mem_ready = 1'b1; #1;
        chk("mrd3_state", bus.state_o, S_MEMRD);
        chk("mrd3_memreq", bus.mem_req, 1);
        tick(); bus.mem_ready = 1'b0; #1;
        chk("mwb_state", bus.state_o, S_MEMWB);
        chk("mwb_rw", bus.reg_write, 1);
        chk("mwb_m2r", bus.mem_to_reg, 1);
        chk("mwb_rdst", bus.reg_dst, 0);
        tick(); #1;
        chk("lw_back_fetch", bus.state_o, S_FETCH);
        tick();

        run(OP_BEQ, 6'd0, 1'b1);
        chk("beq_cyc", ncyc, 3);
        chk("beq_state", snaps[2].st, S_BRANCH);
        chk("beq_pwc", snaps[2].pwc, 1);
        chk("beq_psrc", snaps[2].psrc, 2'b01);
        chk("beq_bne", snaps[2].bne, 0);
        chk("beq_aluop", snaps[2].aop, 4'b0110);
        run(OP_BNE, 6'd0, 1'b1);
        chk("bne_cyc", ncyc, 3);
        chk("bne_pwc", snaps[2].pwc, 1);
        chk("bne_bne", snaps[2].bne, 1);

        run(OP_RTYPE, 6'b000000, 1'b0);
        chk("sll_cyc", ncyc, 4);
        chk("sll_srca", snaps[2].asrc, 2'b10);
        chk("sll_aluop", snaps[2].aop, 4'b1000);
        chk("sll_rdst", snaps[3].rdst, 1);
        chk("sll_rw", snaps[3].rw, 1);
        run(OP_RTYPE, 6'b100010, 1'b0);
        chk("sub_srca", snaps[2].asrc, 2'b01);
        chk("sub_aluop", snaps[2].aop, 4'b0110);

        run(OP_LW, 6'd0, 1'b0);
        chk("lw_cyc", ncyc, 5);
        run(OP_SW, 6'd0, 1'b0);
        chk("sw_cyc", ncyc, 4);
        chk("sw_rw", cnt(1), 0);
        run(OP_ADDI, 6'd0, 1'b0);
        chk("addi_cyc", ncyc, 4);
        chk("addi_sext", snaps[2].sext, 1);
        run(OP_ANDI, 6'd0, 1'b0);
        chk("andi_sext", snaps[2].sext, 0);
        chk("andi_aluop", snaps[2].aop, 4'b0000);
        run(OP_SLTI, 6'd0, 1'b0);
        chk("slti_aluop", snaps[2].aop, 4'b0111);
        run(OP_J, 6'd0, 1'b0);
        chk("j_cyc", ncyc, 3);
        chk("j_psrc", snaps[2].psrc, 2'b10);

        run(6'b111111, 6'd0, 1'b0);
        chk("illop_cyc", ncyc, 2);
        chk("illop_dec", snaps[1].ill, 1);
        chk("illop_cnt", cnt(0), 1);
        chk("illop_rw", cnt(1), 0);
        chk("illop_mreq", cnt(2), 1);
        run(OP_RTYPE, 6'b111111, 1'b0);
        chk("illfn_cyc", ncyc, 3);
        chk("illfn_rt", snaps[2].ill, 1);
        chk("illfn_cnt", cnt(0), 1);
        chk("illfn_rw", cnt(1), 0);

        // Reset in the middle of a completing fetch kills the write immediately
        bus.mem_ready = 1'b1; #1;
        chk("mid_irw_pre", bus.ir_write, 1);
        rst = 1'b0; #1;
        chk("mid_irw_rst", bus.ir_write, 0);
        chk("mid_state", bus.state_o, S_IDLE);
        tick(); rst = 1'b1;
        tick();
        chk("mid_refetch", bus.state_o, S_FETCH);

        // sw whose write never completes
        bus.op = OP_SW; bus.mem_ready = 1'b1;
        tick(); bus.mem_ready = 1'b0;
        tick(); tick();
        w = 0;
        while (bus.state_o == S_MEMWR && w < 40) begin
            #1;
            if (w == 15) chk("to_buserr_pre", bus.bus_err, 0);
            w++;
            tick();
        end
        #1;
        chk("to_waits", w, 16);
        chk("to_state", bus.state_o, S_HALT);
        chk("to_buserr", bus.bus_err, 1);
        chk("to_ctl", w_ctl, 0);
        bus.mem_ready = 1'b1;
        tick(); tick(); tick(); #1;
        chk("halt_stay", bus.state_o, S_HALT);
        chk("halt_buserr", bus.bus_err, 1);
        rst = 1'b0; #1;
        chk("halt_rst_err", bus.bus_err, 0);
        chk("halt_rst_state", bus.state_o, S_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
